// File: rtl/packer_frame_ctrl.sv
// -----------------------------------------------------------------------------
// packer_frame_ctrl
//
// Frame-level sequencer between the traceback output and the 8-bit packer.
// For each accepted start it forwards frame_len payload bits to the packer,
// swallows TAIL_BITS trellis-termination bits, then injects zero pad bits until
// the packer sits on a byte boundary. While the packer holds an unaccepted
// byte (pk_stall) no bit is presented to it and payload input is held off.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   frame start pulse, sampled only in IDLE
//   frame_len  in   payload bit count, captured on an accepted start
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last bit is handed to the packer
//   in_valid   in   upstream decoded bit valid
//   in_bit     in   upstream decoded bit
//   in_ready   out  upstream bit consumed when in_valid && in_ready
//   pk_valid   out  bit strobe to the packer
//   pk_bit     out  bit to the packer
//   pk_stall   in   packer byte pending; no bit is sent while high
// -----------------------------------------------------------------------------
module packer_frame_ctrl #(
  parameter int LEN_W     = 16,
  parameter int TAIL_BITS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             pk_valid,
  output logic             pk_bit,
  input  logic             pk_stall
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_DROP = 3'd2,
    S_PAD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0]       TAIL_INIT = 8'(TAIL_BITS);
  localparam logic [LEN_W-1:0] REM_ONE   = LEN_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] rem;
  logic [7:0]       tail;
  logic [2:0]       pos;
  logic [2:0]       pos_inc;
  logic             run_xfer;
  logic             pad_send;

  assign pos_inc  = pos + 3'd1;
  assign run_xfer = (state == S_RUN) && in_valid && !pk_stall;
  assign pad_send = (state == S_PAD) && !pk_stall;

  // Once the tail is exhausted, only pad if the packer is mid-byte.
  function automatic state_t tail_end(input logic [2:0] p);
    return (p == 3'd0) ? S_DONE : S_PAD;
  endfunction

  // Status outputs are pure decodes of the registered state.
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Next-state decode and combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pk_valid  = 1'b0;
    pk_bit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            state_nxt = S_RUN;
          end else if (TAIL_INIT != 8'd0) begin
            state_nxt = S_DROP;
          end else begin
            state_nxt = tail_end(pos);
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        in_ready = !pk_stall;
        pk_valid = run_xfer;
        pk_bit   = in_bit;
        if (run_xfer && (rem == REM_ONE)) begin
          // With no tail the byte position after this bit decides pad vs done.
          state_nxt = (TAIL_INIT != 8'd0) ? S_DROP : tail_end(pos_inc);
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DROP: begin
        // Tail bits never reach the packer, so its stall is irrelevant here.
        in_ready = 1'b1;
        if (in_valid && (tail == 8'd1)) begin
          state_nxt = tail_end(pos);
        end else begin
          state_nxt = S_DROP;
        end
      end
      S_PAD: begin
        pk_valid = pad_send;
        pk_bit   = 1'b0;
        if (pad_send && (pos == 3'd7)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_PAD;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rem   <= '0;
      tail  <= 8'd0;
      pos   <= 3'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            rem  <= frame_len;
            tail <= TAIL_INIT;
          end
        end
        S_RUN: begin
          if (run_xfer) begin
            rem <= rem - REM_ONE;
            pos <= pos_inc;
          end
        end
        S_DROP: begin
          if (in_valid) begin
            tail <= tail - 8'd1;
          end
        end
        S_PAD: begin
          if (pad_send) begin
            pos <= pos_inc;
          end
        end
        default: begin
          rem <= rem;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packer_frame_ctrl.sv
module tb_packer_frame_ctrl;

  localparam int TAIL = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_len;
  logic        busy;
  logic        done;
  logic        in_valid = 1'b0;
  logic        in_bit   = 1'b0;
  logic        in_ready;
  logic        pk_valid;
  logic        pk_bit;
  logic        pk_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  packer_frame_ctrl #(.LEN_W(16), .TAIL_BITS(TAIL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .frame_len(frame_len),
    .busy     (busy),
    .done     (done),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .pk_valid (pk_valid),
    .pk_bit   (pk_bit),
    .pk_stall (pk_stall)
  );

  // Packer model: LSB-first shift, byte pending for hold_cfg+1 cycles.
  logic [2:0] pcnt;
  logic [7:0] psr;
  logic       out_valid;
  int         hold;
  int         hold_cfg = 0;
  logic [7:0] bytes_q[$];

  assign pk_stall = out_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt      <= 3'd0;
      psr       <= 8'd0;
      out_valid <= 1'b0;
      hold      <= 0;
    end else begin
      if (out_valid) begin
        if (hold >= hold_cfg) begin
          out_valid <= 1'b0;
          hold      <= 0;
        end else begin
          hold <= hold + 1;
        end
      end
      if (pk_valid) begin
        psr[pcnt] <= pk_bit;
        pcnt      <= pcnt + 3'd1;
        if (pcnt == 3'd7) begin
          out_valid <= 1'b1;
          bytes_q.push_back({pk_bit, psr[6:0]});
        end
      end
    end
  end

  // Upstream source: bits of src_bits in order, optional random gaps.
  logic [63:0] src_bits = 64'd0;
  int          src_len  = 0;
  int          acc_base = 0;
  int          flen_exp = 0;
  int          feed_idx;
  bit          gap_en   = 1'b0;

  // Monitor counters (monotonic; tests use deltas).
  int cyc = 0, acc_cnt = 0, sent_cnt = 0, done_cnt = 0;
  int last_acc_cyc = 0, last_pk_cyc = 0, done_cyc = 0;
  int stall_hold = 0, stall_leak = 0, drop_rdy = 0, viol = 0;

  always @(negedge clk) begin
    feed_idx = acc_cnt - acc_base;
    if (feed_idx < src_len && (!gap_en || $urandom_range(0, 2) != 0)) begin
      in_valid = 1'b1;
      in_bit   = src_bits[feed_idx[5:0]];
    end else begin
      in_valid = 1'b0;
      in_bit   = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      acc_cnt      <= acc_cnt + 1;
      last_acc_cyc <= cyc;
    end
    if (pk_valid) begin
      sent_cnt    <= sent_cnt + 1;
      last_pk_cyc <= cyc;
    end
    if (pk_valid && pk_stall) viol <= viol + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy && pk_stall) begin
      if ((acc_cnt - acc_base) < flen_exp) begin
        if (in_ready) stall_leak <= stall_leak + 1;
        else          stall_hold <= stall_hold + 1;
      end else if (in_ready) begin
        drop_rdy <= drop_rdy + 1;
      end
    end
  end

  int b_acc, b_sent, b_done, b_bytes, b_hold, b_leak, b_drop, b_viol;
  bit ok;

  task automatic run_frame(input int len, input logic [63:0] bits, input bit gaps,
                           input int hold_c, input bit restart, output bit fin);
    @(posedge clk); #2;
    b_acc   = acc_cnt;    b_sent = sent_cnt;   b_done = done_cnt;
    b_bytes = bytes_q.size();
    b_hold  = stall_hold; b_leak = stall_leak; b_drop = drop_rdy; b_viol = viol;
    flen_exp  = len;
    src_bits  = bits;
    src_len   = len + TAIL;
    acc_base  = acc_cnt;
    gap_en    = gaps;
    hold_cfg  = hold_c;
    frame_len = 16'(len);
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    if (restart) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #2;
        start     = 1'b1;
        frame_len = 16'd20;
      end
      @(posedge clk); #2;
      start = 1'b0;
    end
    fin = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (done_cnt != b_done) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done got %b want 0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    total++; if (pk_valid !== 1'b0) begin bad++; $display("FAIL rst_pk_valid got %b want 0", pk_valid); end
    total++; if (pk_bit !== 1'b0)   begin bad++; $display("FAIL rst_pk_bit got %b want 0", pk_bit); end
    rst = 1'b0;
    @(posedge clk); #2;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL idle_busy got %b want 0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
  endtask

  task automatic test_basic();
    run_frame(16, 64'h002D_3CA5, 1'b0, 0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got no done want done"); end
    total++; if (bytes_q.size() - b_bytes != 2) begin bad++; $display("FAIL basic_nbytes got %0d want 2", bytes_q.size() - b_bytes); end
    total++; if (bytes_q[b_bytes] !== 8'hA5) begin bad++; $display("FAIL basic_byte0 got %h want a5", bytes_q[b_bytes]); end
    total++; if (bytes_q[b_bytes+1] !== 8'h3C) begin bad++; $display("FAIL basic_byte1 got %h want 3c", bytes_q[b_bytes+1]); end
    total++; if (sent_cnt - b_sent != 16) begin bad++; $display("FAIL basic_sent got %0d want 16", sent_cnt - b_sent); end
    total++; if (acc_cnt - b_acc != 22) begin bad++; $display("FAIL basic_accepted got %0d want 22", acc_cnt - b_acc); end
    total++; if (done_cnt - b_done != 1) begin bad++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - b_done); end
    total++; if (done_cyc != last_acc_cyc + 1) begin bad++; $display("FAIL basic_done_time got %0d want %0d", done_cyc, last_acc_cyc + 1); end
    total++; if (stall_hold - b_hold != 1) begin bad++; $display("FAIL basic_stall_hold got %0d want 1", stall_hold - b_hold); end
    total++; if (stall_leak - b_leak != 0) begin bad++; $display("FAIL basic_stall_leak got %0d want 0", stall_leak - b_leak); end
    total++; if (drop_rdy - b_drop != 1) begin bad++; $display("FAIL basic_drop_ready got %0d want 1", drop_rdy - b_drop); end
    total++; if (viol - b_viol != 0) begin bad++; $display("FAIL basic_send_in_stall got %0d want 0", viol - b_viol); end
  endtask

  task automatic test_pad();
    run_frame(12, 64'h0003_FFFF, 1'b0, 0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL pad_timeout got no done want done"); end
    total++; if (bytes_q.size() - b_bytes != 2) begin bad++; $display("FAIL pad_nbytes got %0d want 2", bytes_q.size() - b_bytes); end
    total++; if (bytes_q[b_bytes] !== 8'hFF) begin bad++; $display("FAIL pad_byte0 got %h want ff", bytes_q[b_bytes]); end
    total++; if (bytes_q[b_bytes+1] !== 8'h0F) begin bad++; $display("FAIL pad_byte1 got %h want 0f", bytes_q[b_bytes+1]); end
    total++; if (sent_cnt - b_sent != 16) begin bad++; $display("FAIL pad_sent got %0d want 16", sent_cnt - b_sent); end
    total++; if (done_cyc != last_pk_cyc + 1) begin bad++; $display("FAIL pad_done_time got %0d want %0d", done_cyc, last_pk_cyc + 1); end
    total++; if (done_cnt - b_done != 1) begin bad++; $display("FAIL pad_done_pulses got %0d want 1", done_cnt - b_done); end
  endtask

  task automatic test_zero_len();
    run_frame(0, 64'h0000_0015, 1'b0, 0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_timeout got no done want done"); end
    total++; if (sent_cnt - b_sent != 0) begin bad++; $display("FAIL zero_sent got %0d want 0", sent_cnt - b_sent); end
    total++; if (acc_cnt - b_acc != 6) begin bad++; $display("FAIL zero_dropped got %0d want 6", acc_cnt - b_acc); end
    total++; if (done_cyc != last_acc_cyc + 1) begin bad++; $display("FAIL zero_done_time got %0d want %0d", done_cyc, last_acc_cyc + 1); end
    total++; if (bytes_q.size() - b_bytes != 0) begin bad++; $display("FAIL zero_nbytes got %0d want 0", bytes_q.size() - b_bytes); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got %b want 0", busy); end
  endtask

  task automatic test_restart();
    run_frame(8, 64'h0000_2AC3, 1'b0, 0, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL restart_timeout got no done want done"); end
    total++; if (bytes_q.size() - b_bytes != 1) begin bad++; $display("FAIL restart_nbytes got %0d want 1", bytes_q.size() - b_bytes); end
    total++; if (bytes_q[b_bytes] !== 8'hC3) begin bad++; $display("FAIL restart_byte got %h want c3", bytes_q[b_bytes]); end
    total++; if (acc_cnt - b_acc != 14) begin bad++; $display("FAIL restart_accepted got %0d want 14", acc_cnt - b_acc); end
    total++; if (done_cnt - b_done != 1) begin bad++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt - b_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy got %b want 0", busy); end
  endtask

  task automatic test_gaps_hold();
    run_frame(20, 64'h033B_3D59, 1'b1, 5, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL gaps_timeout got no done want done"); end
    total++; if (bytes_q.size() - b_bytes != 3) begin bad++; $display("FAIL gaps_nbytes got %0d want 3", bytes_q.size() - b_bytes); end
    total++; if (bytes_q[b_bytes] !== 8'h59) begin bad++; $display("FAIL gaps_byte0 got %h want 59", bytes_q[b_bytes]); end
    total++; if (bytes_q[b_bytes+1] !== 8'h3D) begin bad++; $display("FAIL gaps_byte1 got %h want 3d", bytes_q[b_bytes+1]); end
    total++; if (bytes_q[b_bytes+2] !== 8'h0B) begin bad++; $display("FAIL gaps_byte2 got %h want 0b", bytes_q[b_bytes+2]); end
    total++; if (sent_cnt - b_sent != 24) begin bad++; $display("FAIL gaps_sent got %0d want 24", sent_cnt - b_sent); end
    total++; if (acc_cnt - b_acc != 26) begin bad++; $display("FAIL gaps_accepted got %0d want 26", acc_cnt - b_acc); end
    total++; if (stall_leak - b_leak != 0) begin bad++; $display("FAIL gaps_stall_leak got %0d want 0", stall_leak - b_leak); end
    total++; if (viol - b_viol != 0) begin bad++; $display("FAIL gaps_send_in_stall got %0d want 0", viol - b_viol); end
    total++; if (done_cnt - b_done != 1) begin bad++; $display("FAIL gaps_done_pulses got %0d want 1", done_cnt - b_done); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #2;
    flen_exp  = 16;
    src_bits  = 64'h003F_FFFF;
    src_len   = 22;
    acc_base  = acc_cnt;
    gap_en    = 1'b0;
    hold_cfg  = 0;
    frame_len = 16'd16;
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt - acc_base >= 5) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    total++; if (!ok) begin bad++; $display("FAIL midrst_timeout got no 5 bits want 5 bits"); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL midrst_done got %b want 0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    total++; if (pk_valid !== 1'b0) begin bad++; $display("FAIL midrst_pk_valid got %b want 0", pk_valid); end
    total++; if (pk_bit !== 1'b0)   begin bad++; $display("FAIL midrst_pk_bit got %b want 0", pk_bit); end
    @(posedge clk); #2;
    rst = 1'b0;
    run_frame(8, 64'h0000_156E, 1'b0, 0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL after_rst_timeout got no done want done"); end
    total++; if (bytes_q.size() - b_bytes != 1) begin bad++; $display("FAIL after_rst_nbytes got %0d want 1", bytes_q.size() - b_bytes); end
    total++; if (bytes_q[b_bytes] !== 8'h6E) begin bad++; $display("FAIL after_rst_byte got %h want 6e", bytes_q[b_bytes]); end
    total++; if (done_cnt - b_done != 1) begin bad++; $display("FAIL after_rst_done_pulses got %0d want 1", done_cnt - b_done); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    frame_len = 16'd0;
    test_reset();
    test_basic();
    test_pad();
    test_zero_len();
    test_restart();
    test_gaps_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
